// File: rtl/cdc_pkg.sv
// Shared defaults and helpers for the asynchronous-input conditioner bank.
package cdc_pkg;

  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_BITS = 4;
  localparam int DEF_CNT_BITS    = 8;

  // Width of a channel index; a single channel still needs a 1-bit select.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  localparam int SEL_W = sel_width(DEF_CHANNELS);

  typedef logic [DEF_CNT_BITS-1:0] cnt_t;

  // Increment that sticks at the all-ones value of a 'bits'-wide counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned bits);
    logic [31:0] max_v;
    max_v = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cdc_sync_chan.sv
// One conditioner channel: synchroniser, glitch filter, edge pulses,
// sticky event flag and saturating rising-edge counter.
module cdc_sync_chan
  import cdc_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILTER_BITS = DEF_FILTER_BITS,
  parameter int   CNT_BITS    = DEF_CNT_BITS,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_async,
  input  logic [FILTER_BITS-1:0] i_filt_len,
  input  logic                   i_clr,
  output logic                   o_level,
  output logic                   o_rise,
  output logic                   o_fall,
  output logic                   o_event,
  output logic [CNT_BITS-1:0]    o_edge_cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILTER_BITS-1:0] r_stab_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_event;
  logic [CNT_BITS-1:0]    r_edge_cnt;
  logic                   w_sync_s;

  assign w_sync_s = r_sync[SYNC_STAGES-1];

  // Plain flop chain into the clk domain; nothing between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  // Glitch filter: accept a new level only after it has held past filt_len; >= tolerates a shrinking filt_len.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level    <= RESET_BIT;
      r_stab_cnt <= '0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync_s == r_level) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt >= i_filt_len) begin
        r_level    <= w_sync_s;
        r_stab_cnt <= '0;
        r_rise     <= w_sync_s;
        r_fall     <= ~w_sync_s;
      end else begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // Event flag and edge counter follow the registered pulses; a pulse beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_event    <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      if (r_rise || r_fall) begin
        r_event <= 1'b1;
      end else if (i_clr) begin
        r_event <= 1'b0;
      end
      if (i_clr) begin
        r_edge_cnt <= CNT_BITS'(r_rise);
      end else if (r_rise) begin
        r_edge_cnt <= CNT_BITS'(sat_inc(32'(r_edge_cnt), CNT_BITS));
      end
    end
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_event    = r_event;
  assign o_edge_cnt = r_edge_cnt;

endmodule

// File: rtl/cdc_sync_filter_bank.sv
// Bank of independent asynchronous-input conditioners with a registered
// per-channel edge-count readout.
module cdc_sync_filter_bank
  import cdc_pkg::*;
#(
  parameter int                CHANNELS    = DEF_CHANNELS,
  parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int                FILTER_BITS = DEF_FILTER_BITS,
  parameter int                CNT_BITS    = DEF_CNT_BITS,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             async_in,
  input  logic [FILTER_BITS-1:0]          filt_len,
  input  logic [CHANNELS-1:0]             clr_mask,
  input  logic [sel_width(CHANNELS)-1:0]  rd_sel,
  output logic [CHANNELS-1:0]             level_out,
  output logic [CHANNELS-1:0]             rise_pulse,
  output logic [CHANNELS-1:0]             fall_pulse,
  output logic [CHANNELS-1:0]             event_flag,
  output logic [CNT_BITS-1:0]             rd_count
);

  localparam int RD_SEL_W = sel_width(CHANNELS);
  localparam int RD_SLOTS = 1 << RD_SEL_W;

  // Readout table padded to the full select range so unused indices read zero.
  logic [CNT_BITS-1:0] w_count [0:RD_SLOTS-1];
  logic [CNT_BITS-1:0] r_rd_count;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_chan
    cdc_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_BITS (FILTER_BITS),
      .CNT_BITS    (CNT_BITS),
      .RESET_BIT   (RESET_VAL[g])
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_async    (async_in[g]),
      .i_filt_len (filt_len),
      .i_clr      (clr_mask[g]),
      .o_level    (level_out[g]),
      .o_rise     (rise_pulse[g]),
      .o_fall     (fall_pulse[g]),
      .o_event    (event_flag[g]),
      .o_edge_cnt (w_count[g])
    );
  end

  for (g = CHANNELS; g < RD_SLOTS; g++) begin : g_pad
    assign w_count[g] = '0;
  end

  // Registered counter readout of the selected channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
    end else begin
      r_rd_count <= w_count[rd_sel];
    end
  end

  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_cdc_sync_filter_bank.sv
// Bench for the conditioner bank: vector table, directed corner cases and a
// randomized run against a behavioural reference model.
module tb_cdc_sync_filter_bank;
  import cdc_pkg::*;

  localparam int CH   = 8;
  localparam int SYNC = 2;
  localparam int FB   = 4;
  localparam int CB   = 8;
  localparam int CMAX = (1 << CB) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    async_in;
  logic [FB-1:0]    filt_len;
  logic [CH-1:0]    clr_mask;
  logic [SEL_W-1:0] rd_sel;
  logic [CH-1:0]    level_out;
  logic [CH-1:0]    rise_pulse;
  logic [CH-1:0]    fall_pulse;
  logic [CH-1:0]    event_flag;
  logic [CB-1:0]    rd_count;

  cdc_sync_filter_bank #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SYNC),
    .FILTER_BITS (FB),
    .CNT_BITS    (CB),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .async_in   (async_in),
    .filt_len   (filt_len),
    .clr_mask   (clr_mask),
    .rd_sel     (rd_sel),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_flag (event_flag),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: input history queue, per-channel run length of
  // disagreeing samples, and event/counter bookkeeping from the pulses.
  logic [CH-1:0] m_q[$];
  logic [CH-1:0] m_lvl, m_rise, m_fall, m_flag;
  int            m_run[CH];
  int            m_cnt[CH];
  int            m_rd;

  task automatic model_step();
    logic [CH-1:0] s, old_rise, old_fall;
    if (rst) begin
      m_q = {};
      repeat (SYNC + 1) m_q.push_back('0);
      m_lvl = '0; m_rise = '0; m_fall = '0; m_flag = '0; m_rd = 0;
      for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_cnt[c] = 0; end
      return;
    end
    old_rise = m_rise;
    old_fall = m_fall;
    m_rd = (int'(rd_sel) < CH) ? m_cnt[rd_sel] : 0;
    m_q.push_back(async_in);
    void'(m_q.pop_front());
    s = m_q[0];
    for (int c = 0; c < CH; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (s[c] == m_lvl[c]) begin
        m_run[c] = 0;
      end else if (m_run[c] + 1 > int'(filt_len)) begin
        m_lvl[c]  = s[c];
        m_run[c]  = 0;
        m_rise[c] = s[c];
        m_fall[c] = ~s[c];
      end else begin
        m_run[c] = m_run[c] + 1;
      end
      if (old_rise[c] || old_fall[c]) m_flag[c] = 1'b1;
      else if (clr_mask[c])           m_flag[c] = 1'b0;
      if (clr_mask[c])      m_cnt[c] = old_rise[c] ? 1 : 0;
      else if (old_rise[c]) m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; async_in = '0; clr_mask = '0; rd_sel = '0; filt_len = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic             rst;
    logic [CH-1:0]    a;
    logic [FB-1:0]    fl;
    logic [CH-1:0]    clr;
    logic [SEL_W-1:0] sel;
    logic [CH-1:0]    lvl, rise, fall, flag;
    logic [CB-1:0]    rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [CH-1:0] a, input logic [FB-1:0] fl,
                              input logic [CH-1:0] clr, input logic [CH-1:0] lvl,
                              input logic [CH-1:0] rise, input logic [CH-1:0] fall,
                              input logic [CH-1:0] flag, input logic [CB-1:0] rd);
    vec_t v;
    v.rst = r; v.a = a; v.fl = fl; v.clr = clr; v.sel = '0;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.flag = flag; v.rd = rd;
    tbl.push_back(v);
  endfunction

  initial begin
    int seen, rises, rise_at;
    bit found;

    // reset with inputs high, then filt_len=0 rise/fall, filt_len=5 rise, clear
    add(1, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h01, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h01, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h01, 0, 0, 8'h01, 8'h01, 0, 8'h00, 0);
    add(0, 8'h01, 0, 0, 8'h01, 0, 0, 8'h01, 0);
    add(0, 8'h01, 0, 0, 8'h01, 0, 0, 8'h01, 1);
    add(0, 8'h00, 0, 0, 8'h01, 0, 0, 8'h01, 1);
    add(0, 8'h00, 0, 0, 8'h01, 0, 0, 8'h01, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 8'h01, 8'h01, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h01, 1);
    for (int k = 0; k < 7; k++) add(0, 8'h01, 5, 0, 8'h00, 0, 0, 8'h01, 1);
    add(0, 8'h01, 5, 0, 8'h01, 8'h01, 0, 8'h01, 1);
    add(0, 8'h01, 5, 0, 8'h01, 0, 0, 8'h01, 1);
    add(0, 8'h01, 5, 0, 8'h01, 0, 0, 8'h01, 2);
    add(0, 8'h01, 5, 8'h01, 8'h01, 0, 0, 8'h00, 2);
    add(0, 8'h01, 5, 0, 8'h01, 0, 0, 8'h00, 0);

    rst = 1'b1; async_in = 8'hFF; filt_len = '0; clr_mask = '0; rd_sel = '0;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; async_in = tbl[i].a; filt_len = tbl[i].fl;
      clr_mask = tbl[i].clr; rd_sel = tbl[i].sel;
      tick();
      check($sformatf("tbl%0d.level", i), level_out,  tbl[i].lvl);
      check($sformatf("tbl%0d.rise",  i), rise_pulse, tbl[i].rise);
      check($sformatf("tbl%0d.fall",  i), fall_pulse, tbl[i].fall);
      check($sformatf("tbl%0d.flag",  i), event_flag, tbl[i].flag);
      check($sformatf("tbl%0d.rd",    i), rd_count,   tbl[i].rd);
    end

    // glitch shorter than the filter on ch1
    do_reset();
    filt_len = 4'd3;
    seen = 0;
    async_in[1] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 3) async_in[1] = 1'b0;
      tick();
      seen = seen | int'(level_out[1]) | int'(rise_pulse[1]);
    end
    check("glitch_no_change", seen, 0);
    check("glitch_no_flag", event_flag[1], 1'b0);

    // long enough pulse: exactly one rise, at posedge 2+3+1
    rises = 0; rise_at = 0;
    async_in[1] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 7) async_in[1] = 1'b0;
      tick();
      if (rise_pulse[1]) begin rises++; rise_at = k; end
    end
    check("glitch_long_rises", rises, 1);
    check("glitch_long_latency", rise_at, 6);
    check("glitch_long_flag", event_flag[1], 1'b1);

    // 300 rises on ch2 saturate the counter
    filt_len = '0;
    for (int k = 0; k < 300; k++) begin
      async_in[2] = 1'b1; tick(); tick();
      async_in[2] = 1'b0; tick(); tick();
    end
    repeat (4) tick();
    rd_sel = 3'd2;
    tick();
    check("sat_rd_count", rd_count, 8'hFF);

    // clear in the same cycle as a rise pulse on ch3
    found = 1'b0;
    async_in[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rise_pulse[3]) begin found = 1'b1; break; end
    end
    check("race_rise_seen", found, 1'b1);
    clr_mask = 8'h08;
    tick();
    clr_mask = '0;
    check("race_flag", event_flag[3], 1'b1);
    rd_sel = 3'd3;
    tick();
    check("race_count", rd_count, 8'd1);

    // filt_len shrinks 15->2 while ch4 count is 9
    do_reset();
    filt_len = 4'd15;
    async_in[4] = 1'b1;
    repeat (11) tick();
    check("midop_hold", level_out[4], 1'b0);
    filt_len = 4'd2;
    tick();
    check("midop_level", level_out[4], 1'b1);
    check("midop_rise", rise_pulse[4], 1'b1);
    rd_sel = 3'd4;
    tick(); tick();
    check("midop_count", rd_count, 8'd1);

    // reset in the middle of a filter count
    filt_len = 4'd15;
    async_in[4] = 1'b0;
    repeat (6) tick();
    check("rstmid_pre_level", level_out[4], 1'b1);
    rst = 1'b1;
    tick();
    check("rstmid_level", level_out, 8'h00);
    check("rstmid_rise", rise_pulse, 8'h00);
    check("rstmid_fall", fall_pulse, 8'h00);
    check("rstmid_flag", event_flag, 8'h00);
    check("rstmid_rd", rd_count, 8'h00);
    rst = 1'b0;

    // randomized run against the model
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 50 == 0) filt_len = FB'($urandom_range(0, 4));
      for (int b = 0; b < CH; b++)
        if ($urandom_range(0, 2) == 0) async_in[b] = ~async_in[b];
      clr_mask = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
      rd_sel = SEL_W'($urandom_range(0, CH - 1));
      tick();
      check("rnd.level", level_out,  m_lvl);
      check("rnd.rise",  rise_pulse, m_rise);
      check("rnd.fall",  fall_pulse, m_fall);
      check("rnd.flag",  event_flag, m_flag);
      check("rnd.rd",    rd_count,   m_rd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
